alu_arbiter: RTL

Shares one combinational 32-bit ALU between `N_REQ` requesters. It grants one request at a time in round-robin order, latches the operands and opcode, registers the ALU result and Zero flag, and returns them to the granted requester over a valid/ready response channel. The block sits between the execution front-ends and the team's combinational ALU block (ports A, B, ALU_Sel, ALU_Out, Zero), which it instantiates once.

---
 rtl/alu_arb_pkg.sv | 26 ++
 rtl/alu.sv | 29 ++
 rtl/alu_arbiter_rr_arbiter.sv | 36 +++
 rtl/alu_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared opcodes, FSM states and width default for alu_arbiter
package alu_arb_pkg;

    localparam int DEF_DATA_W = 32;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SUBU = 4'd3;
    localparam logic [3:0] OP_SRX  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Codes 8..15 are outside the ALU's defined operation set
    function automatic logic op_illegal(input logic [3:0] op);
        return op[3];
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU shared by the arbiter
module alu
    import alu_arb_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ALU_Sel,
    output logic [31:0] ALU_Out,
    output logic        Zero
);

    // Operation select; undefined codes yield zero
    always_comb begin
        ALU_Out = '0;
        case (ALU_Sel)
            OP_ADD:          ALU_Out = A + B;
            OP_SUB, OP_SUBU: ALU_Out = A - B;
            OP_SLL:          ALU_Out = A << B[4:0];
            OP_SRX:          ALU_Out = B[31] ? $unsigned($signed(A) >>> B[4:0]) : (A >> B[4:0]);
            OP_XOR:          ALU_Out = A ^ B;
            OP_OR:           ALU_Out = A | B;
            OP_AND:          ALU_Out = A & B;
            default:         ALU_Out = '0;
        endcase
    end

    assign Zero = (ALU_Out == '0);

endmodule

// File: rtl/alu_arbiter_rr_arbiter.sv
// rtl/alu_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    localparam int CW = IDX_W + 1;

    logic [CW-1:0] cand;
    logic          found;

    // Scan requesters from ptr upward with wrap; first valid one wins
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= CW'(N)) begin
                cand = cand - CW'(N);
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU; ALU_ARB_OPCHECK_EN enables illegal-op error responses
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*4-1:0]    req_op,
    output logic [N_REQ-1:0]      resp_valid,
    input  logic [N_REQ-1:0]      resp_ready,
    output logic [DATA_W-1:0]     resp_data,
    output logic                  resp_zero,
    output logic                  resp_err,
    output logic                  busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t              state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    owner;
    logic [N_REQ-1:0]    grant;
    logic [IDX_W-1:0]    grant_idx;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [3:0]          op_q;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [3:0]          sel_op;
    logic [DATA_W-1:0]   alu_out;
    logic                alu_zero;
    logic                accept;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    // The single shared ALU always sees the latched operands
    alu u_alu (
        .A       (a_q),
        .B       (b_q),
        .ALU_Sel (op_q),
        .ALU_Out (alu_out),
        .Zero    (alu_zero)
    );

    assign sel_a  = req_a[grant_idx*DATA_W +: DATA_W];
    assign sel_b  = req_b[grant_idx*DATA_W +: DATA_W];
    assign sel_op = req_op[grant_idx*4 +: 4];

    assign req_ready = (state == IDLE) ? grant : '0;
    assign accept    = (state == IDLE) && (|req_valid);
    assign busy      = (state != IDLE);

    // Response valid is routed only to the requester that owns the operation
    always_comb begin
        resp_valid = '0;
        if (state == RESP) begin
            resp_valid[owner] = 1'b1;
        end
    end

`ifdef ALU_ARB_OPCHECK_EN
    logic err_q;
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    // Request/execute/respond sequencing with registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            resp_data <= '0;
            resp_zero <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        op_q   <= sel_op;
                        owner  <= grant_idx;
                        rr_ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
`ifdef ALU_ARB_OPCHECK_EN
                        if (op_illegal(sel_op)) begin
                            resp_data <= '0;
                            resp_zero <= 1'b0;
                            err_q     <= 1'b1;
                            state     <= RESP;
                        end else begin
                            state <= EXEC;
                        end
`else
                        state <= EXEC;
`endif
                    end
                end
                EXEC: begin
                    resp_data <= alu_out;
                    resp_zero <= alu_zero;
`ifdef ALU_ARB_OPCHECK_EN
                    err_q     <= 1'b0;
`endif
                    state     <= RESP;
                end
                RESP: begin
                    if (resp_ready[owner]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
